uart_hex_parser: RTL

- Receive-side counterpart of the hex logger: consumes the byte stream from the uart RX handshake (ready/read/byte), decodes ASCII hex digits and emits a WIDTH-bit value when a line terminator arrives.
- Sits between the uart instance and user logic, driven from the PLL clock.
- Lets a host set debug/control values by typing e.g. "1A2F\r" at 115,200 baud.

---
 rtl/uart_hex_parser.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/uart_hex_parser.sv
// rtl/uart_hex_parser.sv - ASCII hex line parser on the uart RX handshake; UART_HEX_PARSER_ECHO_EN enables byte echo
module uart_hex_parser #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_ready,
  input  logic [7:0]       rx_byte,
  output logic             rx_read,
  output logic [WIDTH-1:0] hex_val,
  output logic             val_valid,
  output logic             err,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_fifo_full
);

  localparam int DIGITS = WIDTH / 4;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] DIGITS_C = CW'(DIGITS);

  typedef enum logic {S_WAIT, S_ACK} state_t;

  state_t           state_q, state_d;
  logic             rx_read_q, rx_read_d;
  logic [WIDTH-1:0] hex_val_q, hex_val_d;
  logic             val_valid_q, val_valid_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             bad_q, bad_d;

  logic             echo_ok;
  logic             consume;
  logic             is_hex;
  logic [3:0]       nibble;

`ifdef UART_HEX_PARSER_ECHO_EN
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;

  // A byte may only be taken when its echo has room in the TX FIFO
  assign echo_ok = !tx_fifo_full;

  // Echo every consumed byte exactly once, in the cycle after consumption
  always_comb begin
    tx_start_d = consume;
    tx_data_d  = consume ? rx_byte : tx_data_q;
  end

  // Echo registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
`else
  logic unused_tx_fifo_full;

  assign echo_ok             = 1'b1;
  assign unused_tx_fifo_full = tx_fifo_full;
  assign tx_start            = 1'b0;
  assign tx_data             = 8'h00;
`endif

  assign consume = (state_q == S_WAIT) && rx_ready && !rx_read_q && echo_ok;

  // Decode the incoming byte as an ASCII hex digit
  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      is_hex = 1'b1;
      nibble = rx_byte[3:0];
    end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                 (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
      is_hex = 1'b1;
      nibble = rx_byte[3:0] + 4'd9;
    end
  end

  // Handshake FSM plus line accumulation; pulses default low every cycle
  always_comb begin
    state_d     = state_q;
    rx_read_d   = rx_read_q;
    hex_val_d   = hex_val_q;
    val_valid_d = 1'b0;
    err_d       = 1'b0;
    acc_d       = acc_q;
    count_d     = count_q;
    bad_d       = bad_q;
    case (state_q)
      S_WAIT: begin
        if (consume) begin
          rx_read_d = 1'b1;
          state_d   = S_ACK;
          if (rx_byte == 8'h0D || rx_byte == 8'h0A) begin
            if (bad_q) begin
              err_d = 1'b1;
            end else if (count_q != '0) begin
              hex_val_d   = acc_q;
              val_valid_d = 1'b1;
            end
            acc_d   = '0;
            count_d = '0;
            bad_d   = 1'b0;
          end else if (rx_byte == 8'h20) begin
            // spaces are purely cosmetic separators
          end else if (is_hex) begin
            if (count_q < DIGITS_C) begin
              acc_d   = (acc_q << 4) | WIDTH'(nibble);
              count_d = count_q + CW'(1);
            end else begin
              bad_d = 1'b1;
            end
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      S_ACK: begin
        if (!rx_ready) begin
          rx_read_d = 1'b0;
          state_d   = S_WAIT;
        end
      end
      default: begin
        state_d   = S_WAIT;
        rx_read_d = 1'b0;
      end
    endcase
  end

  // Parser state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_WAIT;
      rx_read_q   <= 1'b0;
      hex_val_q   <= '0;
      val_valid_q <= 1'b0;
      err_q       <= 1'b0;
      acc_q       <= '0;
      count_q     <= '0;
      bad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_read_q   <= rx_read_d;
      hex_val_q   <= hex_val_d;
      val_valid_q <= val_valid_d;
      err_q       <= err_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      bad_q       <= bad_d;
    end
  end

  assign rx_read   = rx_read_q;
  assign hex_val   = hex_val_q;
  assign val_valid = val_valid_q;
  assign err       = err_q;

endmodule
